// File: rtl/resumption_ctx_scheduler_if.sv
// Purpose: bundles the requester, step-function and result signals of resumption_ctx_scheduler.
// Latency: none; wires only.
// Backpressure: none; the ack vector is the only flow control (one grant per cycle, no stall).
//
// Signals (direction as seen from the scheduler, i.e. the slave modport):
//   req        in   N       requester i wants one step this cycle
//   req_in     in   N*IW    input for requester i in bits [i*IW +: IW]
//   restart    in   N       reload context i with RESET_STATE and clear halted[i]
//   ack        out  N       one-hot grant for this cycle (combinational)
//   step_state out  SW      context presented to the step function
//   step_in    out  IW      input presented to the step function
//   step_cont  in   1       step function continue bit (0 = resumption finished)
//   step_out   in   OW      step function output
//   step_next  in   SW      step function next context
//   out_valid  out  1       registered result of the previous cycle's step is valid
//   out_id     out  IDW     requester id of the result
//   out_data   out  OW      step output of the result
//   out_halt   out  1       result was the final step of that resumption
//   halted     out  N       per-context finished flags
interface resumption_ctx_scheduler_if #(
   parameter int N  = 4,
   parameter int IW = 1,
   parameter int OW = 1,
   parameter int SW = 2
);
   localparam int IDW = $clog2(N);

   logic [N-1:0]    req;
   logic [N*IW-1:0] req_in;
   logic [N-1:0]    restart;
   logic [N-1:0]    ack;
   logic [SW-1:0]   step_state;
   logic [IW-1:0]   step_in;
   logic            step_cont;
   logic [OW-1:0]   step_out;
   logic [SW-1:0]   step_next;
   logic            out_valid;
   logic [IDW-1:0]  out_id;
   logic [OW-1:0]   out_data;
   logic            out_halt;
   logic [N-1:0]    halted;

   // Requesters plus the step function, seen from outside the scheduler.
   modport master (
      output req, req_in, restart, step_cont, step_out, step_next,
      input  ack, step_state, step_in, out_valid, out_id, out_data, out_halt, halted
   );

   // The scheduler itself.
   modport slave (
      input  req, req_in, restart, step_cont, step_out, step_next,
      output ack, step_state, step_in, out_valid, out_id, out_data, out_halt, halted
   );
endinterface

// File: rtl/resumption_ctx_scheduler.sv
// Purpose: time-multiplexes one combinational resumption step function among N requesters, round-robin.
// Latency: ack and step_state/step_in in cycle t; tagged result on out_* in cycle t+1.
// Backpressure: none; one step per cycle total, un-acked requesters simply retry next cycle.
//
// Ports:
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-high reset
//   bus   slave modport of resumption_ctx_scheduler_if (requests, step-function link, results)
module resumption_ctx_scheduler #(
   parameter int            N           = 4,
   parameter int            IW          = 1,
   parameter int            OW          = 1,
   parameter int            SW          = 2,
   parameter logic [SW-1:0] RESET_STATE = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   resumption_ctx_scheduler_if.slave bus
);
   localparam int IDW = $clog2(N);

   // Saved contexts and flags.
   logic [SW-1:0]  ctx_q [N];
   logic [SW-1:0]  ctx_d [N];
   logic [N-1:0]   halted_q, halted_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

   // Result register.
   logic           out_valid_q, out_valid_d;
   logic [IDW-1:0] out_id_q, out_id_d;
   logic [OW-1:0]  out_data_q, out_data_d;
   logic           out_halt_q, out_halt_d;

   // Arbitration.
   logic [N-1:0]   elig;
   logic           gnt_vld;
   logic [IDW-1:0] gnt_id;
   int             arb_idx;

   // Combinational outputs toward the step function.
   logic [N-1:0]   ack_w;
   logic [SW-1:0]  step_state_w;
   logic [IW-1:0]  step_in_w;

   // A context being restarted is kept out of arbitration, so its restart
   // write and a step write-back can never land on the same flop.
   always_comb begin
      elig    = bus.req & ~halted_q & ~bus.restart;
      gnt_vld = 1'b0;
      gnt_id  = '0;
      arb_idx = 0;
      for (int k = 0; k < N; k++) begin
         arb_idx = int'(rr_ptr_q) + k;
         if (arb_idx >= N) begin
            arb_idx = arb_idx - N;
         end
         if (!gnt_vld && elig[arb_idx[IDW-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_id  = arb_idx[IDW-1:0];
         end
      end
      // Grant outputs must read zero while reset is held, not only after it.
      if (rst) begin
         gnt_vld = 1'b0;
      end
   end

   // Mux the granted context and input out to the step function; zeros when idle.
   always_comb begin
      ack_w        = '0;
      step_state_w = '0;
      step_in_w    = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_vld && (gnt_id == IDW'(i))) begin
            ack_w[i]     = 1'b1;
            step_state_w = ctx_q[i];
            step_in_w    = bus.req_in[i*IW +: IW];
         end
      end
   end

   // Next-state: restart wins over nothing (they are disjoint), step write-back otherwise.
   always_comb begin
      halted_d = halted_q;
      for (int i = 0; i < N; i++) begin
         ctx_d[i] = ctx_q[i];
         if (bus.restart[i]) begin
            ctx_d[i]    = RESET_STATE;
            halted_d[i] = 1'b0;
         end else if (ack_w[i]) begin
            ctx_d[i]    = bus.step_next;
            halted_d[i] = ~bus.step_cont;
         end
      end

      out_valid_d = gnt_vld;
      out_id_d    = out_id_q;
      out_data_d  = out_data_q;
      out_halt_d  = out_halt_q;
      rr_ptr_d    = rr_ptr_q;
      if (gnt_vld) begin
         out_id_d   = gnt_id;
         out_data_d = bus.step_out;
         out_halt_d = ~bus.step_cont;
         // Pointer moves past the winner only when something was granted.
         rr_ptr_d   = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            ctx_q[i] <= RESET_STATE;
         end
         halted_q    <= '0;
         rr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_id_q    <= '0;
         out_data_q  <= '0;
         out_halt_q  <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            ctx_q[i] <= ctx_d[i];
         end
         halted_q    <= halted_d;
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_id_q    <= out_id_d;
         out_data_q  <= out_data_d;
         out_halt_q  <= out_halt_d;
      end
   end

   assign bus.ack        = ack_w;
   assign bus.step_state = step_state_w;
   assign bus.step_in    = step_in_w;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_id     = out_id_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_halt   = out_halt_q;
   assign bus.halted     = halted_q;

   // At most one grant, and never to a finished or restarting context.
   a_ack_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(ack_w));
   a_ack_not_halted : assert property (@(posedge clk) disable iff (rst) (ack_w & halted_q) == '0);
   a_ack_not_restart : assert property (@(posedge clk) disable iff (rst) (ack_w & bus.restart) == '0);

endmodule

// File: tb/tb_resumption_ctx_scheduler.sv
// Purpose: self-checking bench for resumption_ctx_scheduler; the bench also plays the step function.
// Latency: expects ack/step_state in the same cycle and the tagged result one cycle later.
// Backpressure: none; requests are re-driven every cycle by the stimulus.
module tb_resumption_ctx_scheduler;
   localparam int            N      = 4;
   localparam int            IW     = 1;
   localparam int            OW     = 1;
   localparam int            SW     = 2;
   localparam logic [SW-1:0] RST_ST = 2'd1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   resumption_ctx_scheduler_if #(.N(N), .IW(IW), .OW(OW), .SW(SW)) bus ();

   resumption_ctx_scheduler #(
      .N(N), .IW(IW), .OW(OW), .SW(SW), .RESET_STATE(RST_ST)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Step function: next = state+1, out = in ^ state[0], finishes for ids in kill.
   logic [N-1:0] kill;
   assign bus.step_cont = ~|(bus.ack & kill);
   assign bus.step_out  = bus.step_in ^ bus.step_state[0];
   assign bus.step_next = bus.step_state + 2'd1;

   typedef struct packed {
      logic [1:0] id;
      logic       data;
      logic       halt;
   } res_t;
   res_t sb[$];

   // Reference model.
   logic [SW-1:0] m_ctx [N];
   logic [N-1:0]  m_halt;
   int            m_rr;
   logic [1:0]    m_last_id;
   logic          m_last_data;
   logic          m_last_halt;

   int n_chk  = 0;
   int n_pass = 0;

   logic [N-1:0]  seen_ack;
   logic [SW-1:0] seen_state;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h, wanted %0h", tag, got, want);
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_ctx[i] = RST_ST;
      m_halt      = '0;
      m_rr        = 0;
      m_last_id   = '0;
      m_last_data = 1'b0;
      m_last_halt = 1'b0;
      sb.delete();
   endtask

   // One clock cycle: drive, check combinational grant, then check registered result.
   task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] rin, input logic [N-1:0] rs);
      int           g;
      logic [N-1:0] e;
      res_t         it;
      bus.req     = r;
      bus.req_in  = rin;
      bus.restart = rs;
      @(negedge clk);
      e = r & ~m_halt & ~rs;
      g = -1;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (m_rr + k) % N;
         if (g < 0 && e[idx]) g = idx;
      end
      seen_ack   = bus.ack;
      seen_state = bus.step_state;
      if (g >= 0) begin
         chk_eq("ack", 32'(bus.ack), 32'(1) << g);
         chk_eq("step_state", 32'(bus.step_state), 32'(m_ctx[g]));
         chk_eq("step_in", 32'(bus.step_in), 32'(rin[g]));
         it.id   = 2'(g);
         it.data = rin[g] ^ m_ctx[g][0];
         it.halt = kill[g];
         sb.push_back(it);
      end else begin
         chk_eq("idle_ack", 32'(bus.ack), 32'(0));
         chk_eq("idle_step_state", 32'(bus.step_state), 32'(0));
         chk_eq("idle_step_in", 32'(bus.step_in), 32'(0));
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (rs[i]) begin
            m_ctx[i]  = RST_ST;
            m_halt[i] = 1'b0;
         end
      end
      if (g >= 0) begin
         m_ctx[g]  = m_ctx[g] + 2'd1;
         m_halt[g] = kill[g];
         m_rr      = (g + 1) % N;
      end
      chk_eq("out_valid", 32'(bus.out_valid), (g >= 0) ? 32'(1) : 32'(0));
      if (bus.out_valid) begin
         if (sb.size() == 0) begin
            chk_eq("sb_depth", 32'(sb.size()), 32'(1));
         end else begin
            it = sb.pop_front();
            chk_eq("out_id", 32'(bus.out_id), 32'(it.id));
            chk_eq("out_data", 32'(bus.out_data), 32'(it.data));
            chk_eq("out_halt", 32'(bus.out_halt), 32'(it.halt));
            m_last_id   = it.id;
            m_last_data = it.data;
            m_last_halt = it.halt;
         end
      end else begin
         chk_eq("hold_out_id", 32'(bus.out_id), 32'(m_last_id));
         chk_eq("hold_out_data", 32'(bus.out_data), 32'(m_last_data));
         chk_eq("hold_out_halt", 32'(bus.out_halt), 32'(m_last_halt));
      end
      chk_eq("halted", 32'(bus.halted), 32'(m_halt));
   endtask

   logic [N-1:0] ack_tbl [8];

   initial begin
      rst         = 1'b1;
      kill        = '0;
      bus.req     = 4'b1111;
      bus.req_in  = '0;
      bus.restart = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      // Reset state, with requests pending.
      chk_eq("rst_ack", 32'(bus.ack), 32'(0));
      chk_eq("rst_step_state", 32'(bus.step_state), 32'(0));
      chk_eq("rst_out_valid", 32'(bus.out_valid), 32'(0));
      chk_eq("rst_out_id", 32'(bus.out_id), 32'(0));
      chk_eq("rst_halted", 32'(bus.halted), 32'(0));
      #1 rst = 1'b0;

      // 1: all requesting, rotation 0,1,2,3,0,...
      ack_tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      for (int c = 0; c < 8; c++) begin
         cyc(4'b1111, 4'(c * 5), 4'b0000);
         chk_eq("t1_ack_seq", 32'(seen_ack), 32'(ack_tbl[c]));
      end

      // 2: only requester 2; ctx[2] was stepped twice above, then five more.
      for (int c = 0; c < 5; c++) begin
         cyc(4'b0100, 4'b0100, 4'b0000);
         chk_eq("t2_ack", 32'(seen_ack), 32'(4'b0100));
      end
      cyc(4'b0100, 4'b0000, 4'b0000);
      chk_eq("t2_ctx2", 32'(seen_state), 32'(2'(RST_ST + 2'd3)));

      // 3: requester 1 finishes, is ignored, then restarted.
      kill = 4'b0010;
      cyc(4'b0010, 4'b0010, 4'b0000);
      chk_eq("t3_out_halt", 32'(bus.out_halt), 32'(1));
      chk_eq("t3_out_id", 32'(bus.out_id), 32'(1));
      chk_eq("t3_halted1", 32'(bus.halted[1]), 32'(1));
      kill = '0;
      repeat (2) begin
         cyc(4'b0010, 4'b0000, 4'b0000);
         chk_eq("t3_halted_no_ack", 32'(seen_ack), 32'(0));
      end
      cyc(4'b0010, 4'b0000, 4'b0010);
      chk_eq("t3_restart_no_ack", 32'(seen_ack), 32'(0));
      chk_eq("t3_unhalted", 32'(bus.halted[1]), 32'(0));
      cyc(4'b0010, 4'b0000, 4'b0000);
      chk_eq("t3_ack_after_restart", 32'(seen_ack), 32'(4'b0010));
      chk_eq("t3_ctx1_reset", 32'(seen_state), 32'(RST_ST));

      // 4: restart[0] with req[0] and req[3] -> only 3 granted, ctx[0] reloaded.
      cyc(4'b0001, 4'b0000, 4'b0000);
      cyc(4'b1001, 4'b1001, 4'b0001);
      chk_eq("t4_ack", 32'(seen_ack), 32'(4'b1000));
      cyc(4'b0001, 4'b0000, 4'b0000);
      chk_eq("t4_ctx0_reset", 32'(seen_state), 32'(RST_ST));

      // 5: reset between edges while a context is halted and results are flowing.
      kill = 4'b1000;
      repeat (3) cyc(4'b1111, 4'b1010, 4'b0000);
      kill = '0;
      #2 rst = 1'b1;
      #1;
      chk_eq("t5_out_valid", 32'(bus.out_valid), 32'(0));
      chk_eq("t5_halted", 32'(bus.halted), 32'(0));
      chk_eq("t5_ack", 32'(bus.ack), 32'(0));
      chk_eq("t5_step_state", 32'(bus.step_state), 32'(0));
      model_reset();
      @(posedge clk);
      #3 rst = 1'b0;
      cyc(4'b1110, 4'b0000, 4'b0000);
      chk_eq("t5_first_grant", 32'(seen_ack), 32'(4'b0010));
      chk_eq("t5_ctx_reset", 32'(seen_state), 32'(RST_ST));

      // 6: idle cycles hold the last result fields.
      repeat (3) begin
         cyc(4'b0000, 4'b1111, 4'b0000);
         chk_eq("t6_ack", 32'(seen_ack), 32'(0));
      end

      // Mixed random traffic against the model.
      for (int c = 0; c < 80; c++) begin
         kill = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'b0000;
         cyc(4'($urandom()), 4'($urandom()),
             ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'b0000);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
